// File: rtl/button_event_if.sv
// Button event bus: raw button in; debounced level, one-cycle event ticks and FSM state out.
interface button_event_if;
    logic       btn_raw;
    logic       btn_level;
    logic       short_tick;
    logic       long_tick;
    logic       double_tick;
    logic       repeat_tick;
    logic [2:0] state;

    // No handshake: every tick is a single-cycle strobe with no backpressure; consumers must sample every cycle.
    modport master (
        output btn_raw,
        input  btn_level, short_tick, long_tick, double_tick, repeat_tick, state
    );
    modport slave (
        input  btn_raw,
        output btn_level, short_tick, long_tick, double_tick, repeat_tick, state
    );
endinterface

// File: rtl/button_event_ctrl.sv
// Button event controller: debounces btn_raw and classifies short, long and double presses.
// Optional macro BTN_AUTO_REPEAT_EN adds repeat_tick pulses while a long press is held.

module button_debounce #(
    parameter int unsigned FILTER = 2_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);
    localparam int unsigned   CW       = (FILTER > 1) ? $clog2(FILTER) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(FILTER - 1);

    logic          sync0;
    logic          sync1;
    logic [CW-1:0] cnt;
    logic          flip;

    // flip marks the cycle before level takes the new value, so rise/fall line up with that edge
    assign flip = (sync1 != level) && (cnt == CNT_LAST);
    assign rise = flip && sync1;
    assign fall = flip && !sync1;

    always_ff @(posedge clk) begin
        sync0 <= din;
        sync1 <= sync0;
        if (reset) begin
            level <= sync1;
            cnt   <= '0;
        end else if (sync1 == level) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            level <= sync1;
            cnt   <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end
endmodule

module button_event_ctrl #(
    parameter int unsigned FILTER     = 2_000_000,
    parameter int unsigned LONG_CYC   = 100_000_000,
    parameter int unsigned DBL_CYC    = 30_000_000,
    parameter int unsigned REPEAT_CYC = 20_000_000
) (
    input  logic          clk,
    input  logic          reset,
    button_event_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PRESS1 = 3'd1,
        LONG   = 3'd2,
        WAIT2  = 3'd3,
        PRESS2 = 3'd4
    } state_t;

    localparam logic [31:0] LONG_LAST = 32'(LONG_CYC - 1);
    localparam logic [31:0] DBL_LAST  = 32'(DBL_CYC - 1);

    if (FILTER == 0 || LONG_CYC == 0 || DBL_CYC == 0 || REPEAT_CYC == 0) begin : g_param_check
        $error("button_event_ctrl: cycle parameters must be non-zero");
    end

    state_t      st;
    logic [31:0] cnt;
    logic        level;
    logic        press_edge;
    logic        release_edge;
    logic        short_q;
    logic        long_q;
    logic        double_q;

    button_debounce #(.FILTER(FILTER)) u_debounce (
        .clk   (clk),
        .reset (reset),
        .din   (bus.btn_raw),
        .level (level),
        .rise  (press_edge),
        .fall  (release_edge)
    );

    assign bus.btn_level   = level;
    assign bus.state       = st;
    assign bus.short_tick  = short_q;
    assign bus.long_tick   = long_q;
    assign bus.double_tick = double_q;

`ifdef BTN_AUTO_REPEAT_EN
    localparam logic [31:0] REPEAT_LAST = 32'(REPEAT_CYC - 1);
    logic repeat_q;
    assign bus.repeat_tick = repeat_q;
`else
    assign bus.repeat_tick = 1'b0;
`endif

    // Every transition clears cnt; otherwise it counts up and sticks at all-ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            st       <= IDLE;
            cnt      <= '0;
            short_q  <= 1'b0;
            long_q   <= 1'b0;
            double_q <= 1'b0;
`ifdef BTN_AUTO_REPEAT_EN
            repeat_q <= 1'b0;
`endif
        end else begin
            short_q  <= 1'b0;
            long_q   <= 1'b0;
            double_q <= 1'b0;
`ifdef BTN_AUTO_REPEAT_EN
            repeat_q <= 1'b0;
`endif
            cnt <= (cnt == '1) ? cnt : cnt + 32'd1;
            case (st)
                IDLE: begin
                    if (press_edge) begin
                        st  <= PRESS1;
                        cnt <= '0;
                    end
                end
                PRESS1: begin
                    if (release_edge) begin
                        st  <= WAIT2;
                        cnt <= '0;
                    end else if (cnt == LONG_LAST) begin
                        long_q <= 1'b1;
                        st     <= LONG;
                        cnt    <= '0;
                    end
                end
                LONG: begin
`ifdef BTN_AUTO_REPEAT_EN
                    // The level is still high on the release-strobe cycle, so a due repeat still fires.
                    if (cnt == REPEAT_LAST) begin
                        repeat_q <= 1'b1;
                        cnt      <= '0;
                    end
`endif
                    if (release_edge) begin
                        st  <= IDLE;
                        cnt <= '0;
                    end
                end
                WAIT2: begin
                    if (press_edge) begin
                        st  <= PRESS2;
                        cnt <= '0;
                    end else if (cnt == DBL_LAST) begin
                        short_q <= 1'b1;
                        st      <= IDLE;
                        cnt     <= '0;
                    end
                end
                PRESS2: begin
                    if (release_edge) begin
                        double_q <= 1'b1;
                        st       <= IDLE;
                        cnt      <= '0;
                    end
                end
                default: begin
                    st  <= IDLE;
                    cnt <= '0;
                end
            endcase
        end
    end
endmodule

// File: doc/button_event_ctrl.md
BUTTON_EVENT_CTRL -- requirements
Module: button_event_ctrl

Interface
REQ-001 SHALL have parameter FILTER, default 2_000_000, debounce window in clk cycles, passed unchanged to the internal debouncer.
REQ-002 SHALL have parameter LONG_CYC, default 100_000_000, hold length in cycles that classifies a press as long.
REQ-003 SHALL have parameter DBL_CYC, default 30_000_000, the window in cycles after the first release in which a second press counts as a double-click.
REQ-004 SHALL have parameter REPEAT_CYC, default 20_000_000, the auto-repeat period in cycles.
REQ-005 SHALL have port clk, input, 1, the system clock.
REQ-006 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-007 SHALL have port btn_raw, input, 1, the raw asynchronous button (1 = pressed).
REQ-008 SHALL have port btn_level, output, 1, the debounced button level.
REQ-009 SHALL have port short_tick, output, 1, a one-cycle pulse for a single short press.
REQ-010 SHALL have port long_tick, output, 1, a one-cycle pulse when the long-hold threshold is reached.
REQ-011 SHALL have port double_tick, output, 1, a one-cycle pulse for a double-click.
REQ-012 SHALL have port repeat_tick, output, 1, a one-cycle pulse on each auto-repeat while held long.
REQ-013 SHALL have port state, output, 3, the current FSM state code.

Function
REQ-014 SHALL instantiate the team debouncer (FILTER forwarded) on btn_raw; its level drives btn_level and the FSM, and its edge tick marks a press.
REQ-015 SHALL use one 32-bit cycle counter, cleared on every state transition, that saturates and does not wrap.
REQ-016 SHALL implement states IDLE=0, PRESS1=1, LONG=2, WAIT2=3, PRESS2=4; codes 5-7 SHALL return to IDLE on the next cycle.
REQ-017 In IDLE, a debounced rising edge SHALL move the FSM to PRESS1.
REQ-018 In PRESS1, a release with counter < LONG_CYC-1 SHALL move the FSM to WAIT2.
REQ-019 In PRESS1, counter == LONG_CYC-1 while held SHALL pulse long_tick and move the FSM to LONG.
REQ-020 In LONG, a release SHALL move the FSM to IDLE with no further tick.
REQ-021 In WAIT2, a press with counter < DBL_CYC-1 SHALL move the FSM to PRESS2.
REQ-022 In WAIT2, counter == DBL_CYC-1 with no press SHALL pulse short_tick and move the FSM to IDLE.
REQ-023 In PRESS2, a release SHALL pulse double_tick and move the FSM to IDLE, whatever the hold length; long_tick SHALL never fire from PRESS2.
REQ-024 If a release/press coincides with the timeout cycle, the release/press SHALL win over the timeout.
REQ-025 All ticks SHALL be registered, asserted the cycle after the triggering condition, mutually exclusive, and one cycle wide.
REQ-026 End-to-end latency from btn_raw change to btn_level change SHALL be 2 sync cycles + FILTER cycles.

Reset
REQ-027 reset SHALL force state=IDLE, counter=0, and all ticks=0, and SHALL reset the debouncer (btn_level then follows the synchronized input).
REQ-028 Reset asserted mid-press SHALL discard the event with no tick; a held button after reset SHALL NOT count as a new press until it is released and pressed again.

Configuration
REQ-029 With macro BTN_AUTO_REPEAT_EN defined, in LONG, repeat_tick SHALL pulse every REPEAT_CYC cycles after long_tick while the button is held; the first pulse SHALL come REPEAT_CYC cycles after long_tick.
REQ-030 Without BTN_AUTO_REPEAT_EN, repeat_tick SHALL be tied to 0 and the repeat logic SHALL be absent.

Verification (FILTER=4, LONG_CYC=50, DBL_CYC=20, REPEAT_CYC=10)
REQ-031 A 30-cycle press with no second press -> exactly one short_tick, 20 cycles after the debounced release; no other ticks.
REQ-032 A 10-cycle press, a 8-cycle gap, then a 10-cycle press -> one double_tick on the second debounced release; no short_tick.
REQ-033 Hold for 200 cycles with the macro defined -> long_tick once at 50 debounced cycles, then repeat_tick every 10 cycles (15 pulses); without the macro -> no repeat_tick.
REQ-034 3-cycle glitches on btn_raw -> btn_level stays 0, state stays IDLE, no ticks.
REQ-035 reset asserted in PRESS1 and held button kept -> no ticks; a tick fires only after a release and a fresh press.
REQ-036 A release on exactly the WAIT2 timeout-1 cycle versus a press on the same cycle -> PRESS2 is entered and no short_tick is issued.
